// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle for sram_req_ctrl.
// The master drives requests and accepts responses; the slave is the controller.
interface sram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// Single-port SRAM request controller: one write or read at a time, registered outputs.
// Define SRAM_REQ_CNT_EN to add saturating wr_cnt/rd_cnt transaction counters.
module sram_req_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_req_ctrl_if.slave        bus,
  output logic                  wr_en,
  output logic                  rd_enb,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] r_data
`ifdef SRAM_REQ_CNT_EN
  ,
  output logic [15:0]           wr_cnt,
  output logic [15:0]           rd_cnt
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] WAIT_RD = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_enb_q, rd_enb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    w_data_d    = w_data_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_ready_q && bus.req_valid) begin
          addr_d   = bus.req_addr;
          w_data_d = bus.req_wdata;
          state_d  = bus.req_we ? WRITE : READ;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = WAIT_RD;
      WAIT_RD: begin
        rsp_rdata_d = r_data;
        state_d     = RESP;
      end
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered alongside it.
    req_ready_d = (state_d == IDLE);
    wr_en_d     = (state_d == WRITE);
    rd_enb_d    = (state_d == READ);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_enb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      w_data_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      wr_en_q     <= wr_en_d;
      rd_enb_q    <= rd_enb_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      w_data_q    <= w_data_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign wr_en         = wr_en_q;
  assign rd_enb        = rd_enb_q;
  assign addr          = addr_q;
  assign w_data        = w_data_q;

`ifdef SRAM_REQ_CNT_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (wr_en_q && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (rd_enb_q && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl: vector table, corner sequences, random traffic
// against a transaction-level memory model.
module tb_sram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en, rd_enb;
  logic [3:0] addr;
  logic [7:0] w_data;
  logic [7:0] r_data = 8'h00;
`ifdef SRAM_REQ_CNT_EN
  logic [15:0] wr_cnt, rd_cnt;
`endif

  sram_req_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  sram_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .wr_en  (wr_en),
    .rd_enb (rd_enb),
    .addr   (addr),
    .w_data (w_data),
    .r_data (r_data)
`ifdef SRAM_REQ_CNT_EN
    ,
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM with one-cycle read latency.
  logic [7:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (wr_en)  mem[addr] <= w_data;
    if (rd_enb) r_data    <= mem[addr];
  end

  logic both_seen = 1'b0;
  always @(negedge clk) if (wr_en && rd_enb) both_seen <= 1'b1;

  int checks   = 0;
  int failures = 0;
  logic [7:0] model [16];

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    int         stall;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [3:0] a, input logic [7:0] d,
                        input int stall, input logic [7:0] exp);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, bus.req_ready}, 32'd1);
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = (stall == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (we) begin
      chk("wr_strobe", {31'd0, wr_en}, 32'd1);
      chk("wr_no_rd", {31'd0, rd_enb}, 32'd0);
      chk("wr_addr", {28'd0, addr}, {28'd0, a});
      chk("wr_data", {24'd0, w_data}, {24'd0, d});
      chk("wr_busy", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      chk("wr_once", {31'd0, wr_en}, 32'd0);
      chk("wr_ready", {31'd0, bus.req_ready}, 32'd1);
      model[a] = d;
    end else begin
      chk("rd_strobe", {31'd0, rd_enb}, 32'd1);
      chk("rd_no_wr", {31'd0, wr_en}, 32'd0);
      chk("rd_addr", {28'd0, addr}, {28'd0, a});
      chk("rd_busy", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      chk("rd_once", {31'd0, rd_enb}, 32'd0);
      chk("rd_wait_novalid", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rsp_data", {24'd0, bus.rsp_rdata}, {24'd0, exp});
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("rsp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_hold_data", {24'd0, bus.rsp_rdata}, {24'd0, exp});
        chk("rsp_hold_busy", {31'd0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rsp_idle", {31'd0, bus.req_ready}, 32'd1);
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_rd_enb"}, {31'd0, rd_enb}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_addr"}, {28'd0, addr}, 32'd0);
    chk({tag, "_w_data"}, {24'd0, w_data}, 32'd0);
    chk({tag, "_rsp_rdata"}, {24'd0, bus.rsp_rdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{we: 1'b1, a: 4'h3, d: 8'hA5, stall: 0, exp: 8'h00};
    vecs[1] = '{we: 1'b1, a: 4'hC, d: 8'h5A, stall: 0, exp: 8'h00};
    vecs[2] = '{we: 1'b0, a: 4'hC, d: 8'h00, stall: 0, exp: 8'h5A};
    vecs[3] = '{we: 1'b0, a: 4'h3, d: 8'h00, stall: 5, exp: 8'hA5};
    vecs[4] = '{we: 1'b1, a: 4'hF, d: 8'h00, stall: 0, exp: 8'h00};
    vecs[5] = '{we: 1'b0, a: 4'hF, d: 8'h00, stall: 0, exp: 8'h00};
    vecs[6] = '{we: 1'b1, a: 4'h0, d: 8'hFF, stall: 0, exp: 8'h00};
    vecs[7] = '{we: 1'b0, a: 4'h0, d: 8'h00, stall: 1, exp: 8'hFF};

    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'h0;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b0;

    // Reset values, then ready on the first edge after release.
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].stall, vecs[i].exp);

    // A request held during a busy cycle waits and is taken at the next ready.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'h5; bus.req_wdata = 8'h11;
    @(negedge clk);
    chk("hold1_addr", {28'd0, addr}, 32'h5);
    chk("hold1_data", {24'd0, w_data}, 32'h11);
    bus.req_addr = 4'h6; bus.req_wdata = 8'h22;
    @(negedge clk);
    chk("hold_gap_wr", {31'd0, wr_en}, 32'd0);
    chk("hold_gap_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("hold2_wr", {31'd0, wr_en}, 32'd1);
    chk("hold2_addr", {28'd0, addr}, 32'h6);
    chk("hold2_data", {24'd0, w_data}, 32'h22);
    model[5] = 8'h11; model[6] = 8'h22;
    @(negedge clk);
    do_txn(1'b0, 4'h5, 8'h00, 0, 8'h11);
    do_txn(1'b0, 4'h6, 8'h00, 2, 8'h22);

    // Random traffic against the memory model.
    for (int i = 0; i < 60; i++) begin
      logic       we;
      logic [3:0] a;
      logic [7:0] d;
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      do_txn(we, a, d, int'($urandom_range(0, 3)), model[a]);
    end

    // Reset while waiting for read data aborts the read.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'h9; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_rd", {31'd0, rd_enb}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;

    // Back-to-back sweep over all addresses.
    for (int i = 0; i < 16; i++) do_txn(1'b1, 4'(i), 8'(i) ^ 8'hFF, 0, 8'h00);
    for (int i = 0; i < 16; i++) do_txn(1'b0, 4'(i), 8'h00, 0, 8'(i) ^ 8'hFF);
`ifdef SRAM_REQ_CNT_EN
    chk("wr_cnt", {16'd0, wr_cnt}, 32'd16);
    chk("rd_cnt", {16'd0, rd_cnt}, 32'd16);
`endif
    chk("strobe_exclusive", {31'd0, both_seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, the SRAM address width (16 locations).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the SRAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  request address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  read data available.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read response data.
REQ-013 SHALL have port wr_en  output  1  SRAM write strobe.
REQ-014 SHALL have port rd_enb  output  1  SRAM read strobe.
REQ-015 SHALL have port addr  output  ADDR_WIDTH  SRAM address.
REQ-016 SHALL have port w_data  output  DATA_WIDTH  SRAM write data.
REQ-017 SHALL have port r_data  input  DATA_WIDTH  SRAM read data, valid the cycle after rd_enb.

Function
REQ-018 SHALL implement the FSM states IDLE, WRITE, READ, WAIT_RD and RESP, all outputs registered.
REQ-019 SHALL drive req_ready = 1 only in IDLE, and accept a request on a clock edge where req_valid and req_ready are both 1.
REQ-020 SHALL, on accept, capture req_addr/req_wdata into addr/w_data and enter WRITE if req_we = 1, else READ.
REQ-021 SHALL hold wr_en = 1 for exactly one cycle in WRITE, then return to IDLE (2 cycles per write, accept to next req_ready).
REQ-022 SHALL hold rd_enb = 1 for exactly one cycle in READ, then enter WAIT_RD.
REQ-023 SHALL, in WAIT_RD, register r_data into rsp_rdata and enter RESP.
REQ-024 SHALL hold rsp_valid = 1 and rsp_rdata stable in RESP until rsp_ready = 1, then enter IDLE.
REQ-025 SHALL never assert wr_en and rd_enb in the same cycle.
REQ-026 SHALL hold wr_en and rd_enb at 0 in every state except WRITE and READ respectively.
REQ-027 SHALL hold addr and w_data at their last captured values outside WRITE and READ, so they are never X.
REQ-028 SHALL ignore req_valid while req_ready = 0; a request waits upstream and is not dropped.
REQ-029 SHALL accept rsp_ready asserted before rsp_valid without effect, and SHALL NOT use a combinational path from rsp_ready to any output.

Reset
REQ-030 SHALL, while rst = 0, force state IDLE, req_ready = 0, wr_en = 0, rd_enb = 0, rsp_valid = 0, and addr/w_data/rsp_rdata = 0.
REQ-031 SHALL drive req_ready = 1 on the first clock edge after rst rises.
REQ-032 SHALL, on reset in any state, abort the transaction with no partial strobe and no response.

Configuration
REQ-033 SHALL compile transaction counters only when SRAM_REQ_CNT_EN is defined.
REQ-034 SHALL, with SRAM_REQ_CNT_EN defined, provide outputs wr_cnt[15:0] and rd_cnt[15:0], which:
  - increment once per wr_en cycle and once per rd_enb cycle respectively;
  - saturate at 16'hFFFF;
  - reset to 0.
REQ-035 SHALL, without SRAM_REQ_CNT_EN, omit the wr_cnt and rd_cnt ports and logic, with all other behaviour identical.

Verification
REQ-036 SHALL cover a single write: rst released, then req_valid = 1, req_we = 1, req_addr = 4'h3, req_wdata = 8'hA5 -> next cycle wr_en = 1, addr = 3, w_data = A5 for exactly one cycle, and req_ready = 1 again 2 cycles after accept.
REQ-037 SHALL cover a read with latency: write 8'h5A to addr 4'hC, then read addr C with rsp_ready = 1 -> rd_enb for one cycle, rsp_valid 3 cycles after accept, and rsp_rdata = 8'h5A.
REQ-038 SHALL cover response backpressure: a read with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout, and IDLE one cycle after rsp_ready = 1.
REQ-039 SHALL cover reset mid-read: rst driven low during WAIT_RD -> all outputs 0 immediately and no rsp_valid after release.
REQ-040 SHALL cover back-to-back traffic: 16 writes to addresses 0..F with data = addr ^ 8'hFF, then 16 reads -> all responses match, wr_en and rd_enb never both 1, and, with SRAM_REQ_CNT_EN, wr_cnt = 16 and rd_cnt = 16.
